// File: rtl/autoconfig_pkg.sv
// Shared types and constants for the multi-board Zorro II autoconfig responder.
// Register offsets are ADDR[8:1] values inside the $E8xxxx config window.
package autoconfig_pkg;

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [7:0] OFF_TYPE      = 8'h00;
    localparam logic [7:0] OFF_SIZE      = 8'h01;
    localparam logic [7:0] OFF_PROD_HI   = 8'h02;
    localparam logic [7:0] OFF_PROD_LO   = 8'h03;
    localparam logic [7:0] OFF_MFG_FIRST = 8'h08;
    localparam logic [7:0] OFF_MFG_LAST  = 8'h0B;
    localparam logic [7:0] OFF_SER_FIRST = 8'h0C;
    localparam logic [7:0] OFF_SER_LAST  = 8'h13;
    localparam logic [7:0] OFF_ROM_FIRST = 8'h14;
    localparam logic [7:0] OFF_ROM_LAST  = 8'h17;
    localparam logic [7:0] OFF_ZERO_HI   = 8'h20;
    localparam logic [7:0] OFF_ZERO_LO   = 8'h21;
    localparam logic [7:0] OFF_BASE_HI   = 8'h24;
    localparam logic [7:0] OFF_BASE_LO   = 8'h25;
    localparam logic [7:0] OFF_SHUTUP    = 8'h26;

    // Mask over A23..A16: larger windows ignore more low base bits.
    function automatic logic [7:0] size_mask(input logic [2:0] code);
        case (code)
            3'b001:  size_mask = 8'hFF;
            3'b010:  size_mask = 8'hFE;
            3'b011:  size_mask = 8'hFC;
            3'b100:  size_mask = 8'hF8;
            3'b101:  size_mask = 8'hF0;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ac_rom_nibble.sv
// Combinational autoconfig ROM: returns the D15..D12 nibble for a board and offset.
// Offsets 00/01 are presented true, everything else inverted as the bus expects.
module ac_rom_nibble
    import autoconfig_pkg::*;
#(
    parameter int                         NUM_BOARDS = 2,
    parameter int                         CW         = 2,
    parameter logic [15:0]                MFG_ID     = 16'd5194,
    parameter logic [8*NUM_BOARDS-1:0]    PROD_IDS   = {8'd8, 8'd7},
    parameter logic [3*NUM_BOARDS-1:0]    SIZE_CODES = {3'b001, 3'b010},
    parameter logic [NUM_BOARDS-1:0]      ROM_VLD    = 2'b01,
    parameter logic [16*NUM_BOARDS-1:0]   ROM_OFFS   = {16'h0000, 16'h0008},
    parameter logic [31:0]                SERIAL     = 32'h0
) (
    input  logic [CW-1:0] board_i,
    input  logic [7:0]    offset_i,
    input  logic          chained_i,
    output logic [3:0]    nibble_o
);

    logic [7:0]  prod;
    logic [2:0]  size;
    logic        rvld;
    logic [15:0] roffs;
    logic [2:0]  ser_idx;

    always_comb begin
        prod  = '0;
        size  = '0;
        rvld  = 1'b0;
        roffs = '0;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (board_i == CW'(i)) begin
                prod  = PROD_IDS[8*i +: 8];
                size  = SIZE_CODES[3*i +: 3];
                rvld  = ROM_VLD[i];
                roffs = ROM_OFFS[16*i +: 16];
            end
        end
    end

    always_comb begin
        ser_idx  = 3'(offset_i - OFF_SER_FIRST);
        nibble_o = 4'hF;
        if (offset_i == OFF_TYPE) begin
            nibble_o = chained_i ? {2'b11, rvld, 1'b0} : {3'b110, rvld};
        end else if (offset_i == OFF_SIZE) begin
            nibble_o = {1'b0, size};
        end else if (offset_i == OFF_PROD_HI) begin
            nibble_o = ~prod[7:4];
        end else if (offset_i == OFF_PROD_LO) begin
            nibble_o = ~prod[3:0];
        end else if (offset_i >= OFF_MFG_FIRST && offset_i <= OFF_MFG_LAST) begin
            nibble_o = ~MFG_ID[{~offset_i[1:0], 2'b00} +: 4];
        end else if (offset_i >= OFF_SER_FIRST && offset_i <= OFF_SER_LAST) begin
            nibble_o = ~SERIAL[{~ser_idx, 2'b00} +: 4];
        end else if (offset_i >= OFF_ROM_FIRST && offset_i <= OFF_ROM_LAST) begin
            nibble_o = rvld ? ~roffs[{~offset_i[1:0], 2'b00} +: 4] : 4'hF;
        end else if (offset_i == OFF_ZERO_HI || offset_i == OFF_ZERO_LO) begin
            nibble_o = 4'h0;
        end
    end

endmodule

// File: rtl/autoconfig_multi.sv
// Presents NUM_BOARDS Zorro II autoconfig functions one after another on a single
// card, then decodes accesses to each configured board's assigned window.
module autoconfig_multi
    import autoconfig_pkg::*;
#(
    parameter int                         NUM_BOARDS = 2,
    parameter logic [15:0]                MFG_ID     = 16'd5194,
    parameter logic [8*NUM_BOARDS-1:0]    PROD_IDS   = {8'd8, 8'd7},
    parameter logic [3*NUM_BOARDS-1:0]    SIZE_CODES = {3'b001, 3'b010},
    parameter logic [NUM_BOARDS-1:0]      ROM_VLD    = 2'b01,
    parameter logic [16*NUM_BOARDS-1:0]   ROM_OFFS   = {16'h0000, 16'h0008},
    parameter logic [31:0]                SERIAL     = 32'h0
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [23:1]               ADDR,
    input  logic                      AS_n,
    input  logic                      UDS_n,
    input  logic                      RW,
    input  logic [3:0]                DIN,
    input  logic                      CFGIN_n,
    input  logic [NUM_BOARDS-1:0]     board_en,
    output logic [3:0]                DOUT,
    output logic                      dtack,
    output logic                      autoconfig_cycle,
    output logic                      CFGOUT_n,
    output logic [NUM_BOARDS-1:0]     board_access,
    output logic [8*NUM_BOARDS-1:0]   board_base
);

    // cur may step one past the last board, which is how SCAN finds the end.
    localparam int CW = $clog2(NUM_BOARDS + 1);

    state_e                     state_q, state_d;
    logic [CW-1:0]              cur_q, cur_d;
    logic                       as_q;
    logic                       dtack_q, dtack_d;
    logic [3:0]                 dout_q, dout_d;
    logic [8*NUM_BOARDS-1:0]    base_q, base_d;
    logic [NUM_BOARDS-1:0]      cfg_q, cfg_d;
    logic [NUM_BOARDS-1:0]      shut_q, shut_d;
    logic                       cfgout_n_q, cfgout_n_d;

    logic       cur_en, cur_cfg, cur_shut, chained;
    logic       rd_qual, wr_qual, cycle_end;
    logic [7:0] offs;
    logic [3:0] rom_nib;
    logic [7:0] acc_mask;
    logic       unused_addr;

    assign offs        = ADDR[8:1];
    assign unused_addr = ^ADDR[15:9];

    assign autoconfig_cycle = (ADDR[23:16] == 8'hE8) && !CFGIN_n && (state_q == ST_ACTIVE);
    assign rd_qual   = autoconfig_cycle && !AS_n && RW && !dtack_q;
    assign wr_qual   = autoconfig_cycle && !AS_n && !UDS_n && !RW && !dtack_q;
    assign cycle_end = !as_q && AS_n;

    always_comb begin
        cur_en   = 1'b0;
        cur_cfg  = 1'b0;
        cur_shut = 1'b0;
        chained  = 1'b0;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (cur_q == CW'(i)) begin
                cur_en   = board_en[i];
                cur_cfg  = cfg_q[i];
                cur_shut = shut_q[i];
            end
            if (CW'(i) > cur_q && board_en[i]) begin
                chained = 1'b1;
            end
        end
    end

    ac_rom_nibble #(
        .NUM_BOARDS (NUM_BOARDS),
        .CW         (CW),
        .MFG_ID     (MFG_ID),
        .PROD_IDS   (PROD_IDS),
        .SIZE_CODES (SIZE_CODES),
        .ROM_VLD    (ROM_VLD),
        .ROM_OFFS   (ROM_OFFS),
        .SERIAL     (SERIAL)
    ) u_rom (
        .board_i   (cur_q),
        .offset_i  (offs),
        .chained_i (chained),
        .nibble_o  (rom_nib)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        base_d     = base_q;
        cfg_d      = cfg_q;
        shut_d     = shut_q;
        dout_d     = rd_qual ? rom_nib : dout_q;
        dtack_d    = dtack_q ? !AS_n : (rd_qual || wr_qual);

        // A board that is configured or shut up takes no further writes.
        if (wr_qual && !cur_cfg && !cur_shut) begin
            for (int i = 0; i < NUM_BOARDS; i++) begin
                if (cur_q == CW'(i)) begin
                    case (offs)
                        OFF_BASE_LO: base_d[8*i +: 4] = DIN;
                        OFF_BASE_HI: begin
                            base_d[8*i+4 +: 4] = DIN;
                            cfg_d[i]           = 1'b1;
                        end
                        OFF_SHUTUP:  shut_d[i] = 1'b1;
                        default:     ;
                    endcase
                end
            end
        end

        case (state_q)
            ST_SCAN: begin
                if (cur_q >= CW'(NUM_BOARDS)) begin
                    state_d = ST_DONE;
                end else if (cur_en) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cur_d = cur_q + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cycle_end && (cur_cfg || cur_shut)) begin
                    state_d = ST_SCAN;
                    cur_d   = cur_q + 1'b1;
                end
            end
            ST_DONE:  ;
            default:  state_d = ST_SCAN;
        endcase

        cfgout_n_d = cfgout_n_q && (state_d != ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_SCAN;
            cur_q      <= '0;
            as_q       <= 1'b1;
            dtack_q    <= 1'b0;
            dout_q     <= '0;
            base_q     <= '0;
            cfg_q      <= '0;
            shut_q     <= '0;
            cfgout_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            as_q       <= AS_n;
            dtack_q    <= dtack_d;
            dout_q     <= dout_d;
            base_q     <= base_d;
            cfg_q      <= cfg_d;
            shut_q     <= shut_d;
            cfgout_n_q <= cfgout_n_d;
        end
    end

    always_comb begin
        board_access = '0;
        acc_mask     = 8'hFF;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            acc_mask = size_mask(SIZE_CODES[3*i +: 3]);
            board_access[i] = cfg_q[i] && !shut_q[i] && (state_q == ST_DONE)
                              && ((ADDR[23:16] & acc_mask) == (base_q[8*i +: 8] & acc_mask));
        end
    end

    assign DOUT       = dout_q;
    assign dtack      = dtack_q;
    assign CFGOUT_n   = cfgout_n_q;
    assign board_base = base_q;

endmodule

// File: tb/tb_autoconfig_multi.sv
// Directed bench for autoconfig_multi with default parameters (two boards).
module tb_autoconfig_multi;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [23:1] ADDR;
    logic        AS_n, UDS_n, RW;
    logic [3:0]  DIN;
    logic        CFGIN_n;
    logic [1:0]  board_en;
    logic [3:0]  DOUT;
    logic        dtack;
    logic        autoconfig_cycle;
    logic        CFGOUT_n;
    logic [1:0]  board_access;
    logic [15:0] board_base;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 CLK = ~CLK;

    autoconfig_multi dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .ADDR             (ADDR),
        .AS_n             (AS_n),
        .UDS_n            (UDS_n),
        .RW               (RW),
        .DIN              (DIN),
        .CFGIN_n          (CFGIN_n),
        .board_en         (board_en),
        .DOUT             (DOUT),
        .dtack            (dtack),
        .autoconfig_cycle (autoconfig_cycle),
        .CFGOUT_n         (CFGOUT_n),
        .board_access     (board_access),
        .board_base       (board_base)
    );

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1; AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
        CFGIN_n = 1'b0; DIN = 4'h0; ADDR = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;
    endtask

    // One full bus cycle at $E8; returns the latched nibble and whether dtack came.
    task automatic bus_cycle(input logic rw, input logic [7:0] off, input logic [3:0] wd,
                             output logic [3:0] rd, output logic ok);
        @(negedge CLK);
        ADDR = {8'hE8, 7'd0, off}; RW = rw; DIN = wd; AS_n = 1'b0; UDS_n = 1'b0;
        ok = 1'b0;
        rd = 4'hX;
        for (int n = 0; n < 20; n++) begin
            @(posedge CLK); #1;
            if (dtack) begin
                ok = 1'b1;
                rd = DOUT;
                break;
            end
        end
        @(negedge CLK);
        AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        board_en = 2'b11; RESET = 1'b1; AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
        CFGIN_n = 1'b0; DIN = 4'h0; ADDR = {8'hE8, 15'd0};
        repeat (3) @(posedge CLK); #1;
        total_cnt++; if (dtack !== 1'b0) $display("FAIL rst_dtack: got %b want 0", dtack); else pass_cnt++;
        total_cnt++; if (DOUT !== 4'h0) $display("FAIL rst_dout: got %h want 0", DOUT); else pass_cnt++;
        total_cnt++; if (CFGOUT_n !== 1'b1) $display("FAIL rst_cfgout: got %b want 1", CFGOUT_n); else pass_cnt++;
        total_cnt++; if (board_access !== 2'b00) $display("FAIL rst_access: got %b want 00", board_access); else pass_cnt++;
        total_cnt++; if (board_base !== 16'h0000) $display("FAIL rst_base: got %h want 0000", board_base); else pass_cnt++;
        total_cnt++; if (autoconfig_cycle !== 1'b0) $display("FAIL rst_accyc: got %b want 0", autoconfig_cycle); else pass_cnt++;
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;
        total_cnt++; if (autoconfig_cycle !== 1'b1) $display("FAIL post_rst_accyc: got %b want 1", autoconfig_cycle); else pass_cnt++;
    endtask

    task automatic test_defaults();
        logic [3:0] d;
        logic ok;
        board_en = 2'b11;
        do_reset();
        bus_cycle(1'b1, 8'h01, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'b0010) $display("FAIL b0_size: got %h ok=%b want 2", d, ok); else pass_cnt++;
        bus_cycle(1'b1, 8'h00, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'hE) $display("FAIL b0_type: got %h ok=%b want e", d, ok); else pass_cnt++;
        bus_cycle(1'b1, 8'h03, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'h8) $display("FAIL b0_prod_lo: got %h ok=%b want 8", d, ok); else pass_cnt++;
        bus_cycle(1'b1, 8'h08, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'hE) $display("FAIL b0_mfg0: got %h ok=%b want e", d, ok); else pass_cnt++;
        bus_cycle(1'b1, 8'h0B, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'h5) $display("FAIL b0_mfg3: got %h ok=%b want 5", d, ok); else pass_cnt++;
        bus_cycle(1'b1, 8'h0C, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'hF) $display("FAIL b0_ser0: got %h ok=%b want f", d, ok); else pass_cnt++;
        bus_cycle(1'b1, 8'h17, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'h7) $display("FAIL b0_rom3: got %h ok=%b want 7", d, ok); else pass_cnt++;
        bus_cycle(1'b1, 8'h20, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'h0) $display("FAIL b0_zero: got %h ok=%b want 0", d, ok); else pass_cnt++;
        bus_cycle(1'b1, 8'h30, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'hF) $display("FAIL b0_other: got %h ok=%b want f", d, ok); else pass_cnt++;
        bus_cycle(1'b1, 8'h01, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'b0010) $display("FAIL b0_still_active: got %h ok=%b want 2", d, ok); else pass_cnt++;
        bus_cycle(1'b0, 8'h25, 4'h0, d, ok);
        bus_cycle(1'b0, 8'h24, 4'h2, d, ok);
        total_cnt++; if (!ok) $display("FAIL b0_wr24_ack: got ok=%b want 1", ok); else pass_cnt++;
        bus_cycle(1'b1, 8'h01, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'b0001) $display("FAIL b1_size: got %h ok=%b want 1", d, ok); else pass_cnt++;
        bus_cycle(1'b1, 8'h00, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'hC) $display("FAIL b1_type: got %h ok=%b want c", d, ok); else pass_cnt++;
        bus_cycle(1'b1, 8'h14, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'hF) $display("FAIL b1_norom: got %h ok=%b want f", d, ok); else pass_cnt++;
        total_cnt++; if (board_base !== 16'h0020) $display("FAIL b0_base: got %h want 0020", board_base); else pass_cnt++;
    endtask

    // Continues from test_defaults: board 1 is active, board 0 sits at $20.
    task automatic test_access();
        logic [3:0] d;
        logic ok;
        bus_cycle(1'b0, 8'h25, 4'h0, d, ok);
        bus_cycle(1'b0, 8'h24, 4'h4, d, ok);
        repeat (2) @(posedge CLK); #1;
        total_cnt++; if (CFGOUT_n !== 1'b0) $display("FAIL acc_cfgout: got %b want 0", CFGOUT_n); else pass_cnt++;
        total_cnt++; if (board_base !== 16'h4020) $display("FAIL acc_base: got %h want 4020", board_base); else pass_cnt++;
        @(negedge CLK); ADDR = {8'h21, 15'd0}; #1;
        total_cnt++; if (board_access !== 2'b01) $display("FAIL acc_21: got %b want 01", board_access); else pass_cnt++;
        @(negedge CLK); ADDR = {8'h22, 15'd0}; #1;
        total_cnt++; if (board_access !== 2'b00) $display("FAIL acc_22: got %b want 00", board_access); else pass_cnt++;
        @(negedge CLK); ADDR = {8'h40, 15'd0}; #1;
        total_cnt++; if (board_access !== 2'b10) $display("FAIL acc_40: got %b want 10", board_access); else pass_cnt++;
        @(negedge CLK); ADDR = {8'h41, 15'd0}; #1;
        total_cnt++; if (board_access !== 2'b00) $display("FAIL acc_41: got %b want 00", board_access); else pass_cnt++;
        @(negedge CLK); ADDR = {8'hE8, 15'd0}; #1;
        total_cnt++; if (autoconfig_cycle !== 1'b0) $display("FAIL done_accyc: got %b want 0", autoconfig_cycle); else pass_cnt++;
        bus_cycle(1'b1, 8'h01, 4'h0, d, ok);
        total_cnt++; if (ok !== 1'b0) $display("FAIL done_no_ack: got ok=%b want 0", ok); else pass_cnt++;
    endtask

    task automatic test_skip();
        logic [3:0] d;
        logic ok;
        board_en = 2'b10;
        do_reset();
        bus_cycle(1'b1, 8'h01, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'b0001) $display("FAIL skip_size: got %h ok=%b want 1", d, ok); else pass_cnt++;
        bus_cycle(1'b1, 8'h00, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'hC) $display("FAIL skip_type: got %h ok=%b want c", d, ok); else pass_cnt++;
        bus_cycle(1'b0, 8'h25, 4'h0, d, ok);
        bus_cycle(1'b0, 8'h24, 4'h6, d, ok);
        total_cnt++; if (CFGOUT_n !== 1'b1) $display("FAIL skip_cfgout_1clk: got %b want 1", CFGOUT_n); else pass_cnt++;
        @(posedge CLK); #1;
        total_cnt++; if (CFGOUT_n !== 1'b0) $display("FAIL skip_cfgout_2clk: got %b want 0", CFGOUT_n); else pass_cnt++;
        @(negedge CLK); ADDR = {8'h60, 15'd0}; #1;
        total_cnt++; if (board_access !== 2'b10) $display("FAIL skip_acc_60: got %b want 10", board_access); else pass_cnt++;
    endtask

    task automatic test_shutup();
        logic [3:0] d;
        logic ok;
        int hits0;
        board_en = 2'b11;
        do_reset();
        bus_cycle(1'b0, 8'h26, 4'h0, d, ok);
        bus_cycle(1'b1, 8'h01, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'b0001) $display("FAIL shut_next: got %h ok=%b want 1", d, ok); else pass_cnt++;
        bus_cycle(1'b0, 8'h25, 4'h0, d, ok);
        bus_cycle(1'b0, 8'h24, 4'h4, d, ok);
        repeat (2) @(posedge CLK); #1;
        total_cnt++; if (CFGOUT_n !== 1'b0) $display("FAIL shut_cfgout: got %b want 0", CFGOUT_n); else pass_cnt++;
        hits0 = 0;
        for (int a = 0; a < 256; a++) begin
            ADDR = {8'(a), 15'd0}; #1;
            if (board_access[0]) hits0++;
        end
        total_cnt++; if (hits0 != 0) $display("FAIL shut_acc0: got %0d hits want 0", hits0); else pass_cnt++;
        @(negedge CLK); ADDR = {8'h40, 15'd0}; #1;
        total_cnt++; if (board_access !== 2'b10) $display("FAIL shut_acc_40: got %b want 10", board_access); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int rises;
        logic prev;
        logic [3:0] d;
        logic ok;
        board_en = 2'b11;
        do_reset();
        @(negedge CLK);
        ADDR = {8'hE8, 7'd0, 8'h24}; RW = 1'b0; DIN = 4'h2; AS_n = 1'b0; UDS_n = 1'b0;
        rises = 0;
        prev  = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge CLK); #1;
            if (dtack && !prev) rises++;
            prev = dtack;
            @(negedge CLK);
            DIN = 4'(n + 3);
        end
        total_cnt++; if (rises != 1) $display("FAIL b2b_dtack_count: got %0d want 1", rises); else pass_cnt++;
        total_cnt++; if (board_base[7:0] !== 8'h20) $display("FAIL b2b_base: got %h want 20", board_base[7:0]); else pass_cnt++;
        AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
        @(posedge CLK); #1;
        total_cnt++; if (dtack !== 1'b0) $display("FAIL b2b_dtack_clear: got %b want 0", dtack); else pass_cnt++;
        bus_cycle(1'b1, 8'h01, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'b0001) $display("FAIL b2b_next: got %h ok=%b want 1", d, ok); else pass_cnt++;
    endtask

    task automatic test_cfgin_mid();
        logic [3:0] d;
        logic ok;
        board_en = 2'b11;
        do_reset();
        @(negedge CLK);
        ADDR = {8'hE8, 7'd0, 8'h01}; RW = 1'b1; AS_n = 1'b0; UDS_n = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge CLK); #1;
            if (dtack) begin ok = 1'b1; break; end
        end
        total_cnt++; if (!ok) $display("FAIL cfgin_ack: got ok=%b want 1", ok); else pass_cnt++;
        @(negedge CLK); CFGIN_n = 1'b1; #1;
        total_cnt++; if (autoconfig_cycle !== 1'b0) $display("FAIL cfgin_accyc: got %b want 0", autoconfig_cycle); else pass_cnt++;
        @(posedge CLK); #1;
        total_cnt++; if (dtack !== 1'b1) $display("FAIL cfgin_dtack_hold: got %b want 1", dtack); else pass_cnt++;
        @(negedge CLK); AS_n = 1'b1; UDS_n = 1'b1;
        @(posedge CLK); #1;
        total_cnt++; if (dtack !== 1'b0) $display("FAIL cfgin_dtack_clear: got %b want 0", dtack); else pass_cnt++;
        CFGIN_n = 1'b0;
        bus_cycle(1'b1, 8'h01, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'b0010) $display("FAIL cfgin_state: got %h ok=%b want 2", d, ok); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] d;
        logic ok;
        board_en = 2'b11;
        do_reset();
        bus_cycle(1'b0, 8'h25, 4'h3, d, ok);
        bus_cycle(1'b0, 8'h24, 4'h2, d, ok);
        @(negedge CLK);
        ADDR = {8'hE8, 7'd0, 8'h01}; RW = 1'b1; AS_n = 1'b0; UDS_n = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge CLK); #1;
            if (dtack) begin ok = 1'b1; break; end
        end
        total_cnt++; if (!ok || DOUT !== 4'b0001) $display("FAIL rmid_pre: got %h ok=%b want 1", DOUT, ok); else pass_cnt++;
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;
        total_cnt++; if (dtack !== 1'b0) $display("FAIL rmid_dtack: got %b want 0", dtack); else pass_cnt++;
        total_cnt++; if (DOUT !== 4'h0) $display("FAIL rmid_dout: got %h want 0", DOUT); else pass_cnt++;
        total_cnt++; if (board_base !== 16'h0000) $display("FAIL rmid_base: got %h want 0000", board_base); else pass_cnt++;
        total_cnt++; if (CFGOUT_n !== 1'b1) $display("FAIL rmid_cfgout: got %b want 1", CFGOUT_n); else pass_cnt++;
        @(negedge CLK); AS_n = 1'b1; UDS_n = 1'b1; RESET = 1'b0;
        @(posedge CLK); #1;
        bus_cycle(1'b1, 8'h01, 4'h0, d, ok);
        total_cnt++; if (!ok || d !== 4'b0010) $display("FAIL rmid_b0_again: got %h ok=%b want 2", d, ok); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_access();
        test_skip();
        test_shutup();
        test_back_to_back();
        test_cfgin_mid();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
